// File: rtl/bridge_req_arbiter_reg.sv
// ---------------------------------------------------------------------------
// bridge_req_arbiter_reg
//   Registered round-robin N-to-1 request arbiter for the L2 bridge master
//   side. A single-entry output slot presents a registered req/payload to the
//   bridge. An outstanding-transaction counter bounds the number of issued but
//   unanswered requests to MAX_OUTSTANDING.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   data_req_i        per-master request
//   data_*_i          packed per-master payload, master m at [m*W +: W]
//   data_gnt_o        one-hot combinational grant back to the masters
//   data_req_o        registered request to the bridge (slot FULL)
//   data_*_o          registered payload of the request held in the slot
//   data_gnt_i        bridge grant; handshake = data_req_o && data_gnt_i
//   data_r_valid_i    one response returned, frees one credit
//   outstanding_o     issued-but-unanswered request count
// ---------------------------------------------------------------------------
module bridge_req_arbiter_reg #(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 20,
  parameter int AUX_WIDTH       = 6,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PW             = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_MASTER-1:0]              data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]   data_add_i,
  input  logic [N_MASTER-1:0]              data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]     data_be_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]     data_ID_i,
  input  logic [N_MASTER*AUX_WIDTH-1:0]    data_aux_i,
  output logic [N_MASTER-1:0]              data_gnt_o,
  output logic                             data_req_o,
  output logic [ADDR_WIDTH-1:0]            data_add_o,
  output logic                             data_wen_o,
  output logic [DATA_WIDTH-1:0]            data_wdata_o,
  output logic [BE_WIDTH-1:0]              data_be_o,
  output logic [ID_WIDTH-1:0]              data_ID_o,
  output logic [AUX_WIDTH-1:0]             data_aux_o,
  input  logic                             data_gnt_i,
  input  logic                             data_r_valid_i,
  output logic [CW-1:0]                    outstanding_o
);

  // Slot state; FULL is exactly data_req_o, so no separate state flop exists.
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  slot_e          slot;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  winner;
  logic           any_req;
  logic           accept_ok;
  logic           accept;
  logic           handshake;
  logic           credit_ret;

  assign slot = slot_e'(data_req_o);

  // First requesting master at or after rr_ptr, wrapping modulo N_MASTER.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      int sum;
      sum = int'(rr_ptr) + i;
      if (sum >= N_MASTER) sum = sum - N_MASTER;
      if (!any_req && data_req_i[PW'(sum)]) begin
        any_req = 1'b1;
        winner  = PW'(sum);
      end
    end
  end

  // Only registered state decides acceptance, so a returning credit is
  // usable one cycle after data_r_valid_i.
  assign accept_ok = ((slot == SLOT_EMPTY) || data_gnt_i) &&
                     (({1'b0, outstanding_o} + (CW+1)'(data_req_o)) <
                      (CW+1)'(MAX_OUTSTANDING));

  // rst_n gates the grant: during reset the slot cannot capture, so a grant
  // would tell a master its request was taken when it was not.
  assign accept     = accept_ok && any_req && rst_n;
  assign handshake  = data_req_o && data_gnt_i;
  assign credit_ret = data_r_valid_i && (outstanding_o != '0);

  assign data_gnt_o = accept ? (N_MASTER'(1) << winner) : '0;

  // Slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: payload registers are reset as well, so the bridge never sees
      // X on the bus after reset even though data_req_o qualifies them.
      data_req_o   <= 1'b0;
      data_add_o   <= '0;
      data_wen_o   <= 1'b0;
      data_wdata_o <= '0;
      data_be_o    <= '0;
      data_ID_o    <= '0;
      data_aux_o   <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      data_req_o   <= 1'b1;
      data_add_o   <= data_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      data_wen_o   <= data_wen_i[winner];
      data_wdata_o <= data_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      data_be_o    <= data_be_i[winner*BE_WIDTH +: BE_WIDTH];
      data_ID_o    <= data_ID_i[winner*ID_WIDTH +: ID_WIDTH];
      data_aux_o   <= data_aux_i[winner*AUX_WIDTH +: AUX_WIDTH];
      rr_ptr       <= (winner == PW'(N_MASTER - 1)) ? '0 : winner + 1'b1;
    end else if (handshake) begin
      // Payload keeps its last value; only the request drops.
      data_req_o   <= 1'b0;
    end
  end

  // Outstanding counter: +1 per handshake, -1 per response, saturating at 0.
  // The credit check in accept_ok keeps it from exceeding MAX_OUTSTANDING.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o <= '0;
    end else if (handshake && !credit_ret) begin
      outstanding_o <= outstanding_o + 1'b1;
    end else if (!handshake && credit_ret) begin
      outstanding_o <= outstanding_o - 1'b1;
    end
  end

endmodule
